// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register offsets, control/status
// bit positions, slave handshake states and the byte-lane merge helper.
package wb_timer_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PRESC   = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    localparam logic [7:0] ADDR_LIMIT  = 8'h14;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_AR     = 2;
    localparam int STATUS_PEND = 0;

    typedef enum logic [0:0] {
        SLV_IDLE = 1'b0,
        SLV_RESP = 1'b1
    } slv_state_e;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Generic Wishbone slave front end: two-state handshake, address range decode,
// registered ack/err/read-data and a single-cycle write strobe to the register file.
module wb_slave_if
    import wb_timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [7:0]  adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        reg_wr_o,
    output logic [2:0]  reg_idx_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_sel_o
);

    slv_state_e  state_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] dat_q;
    logic        sample;
    logic        addr_ok;

    // A request is only taken from IDLE, which enforces the idle cycle after every response.
    assign sample    = cyc_i & stb_i & (state_q == SLV_IDLE);
    assign addr_ok   = (adr_i < ADDR_LIMIT);
    assign reg_wr_o  = sample & we_i & addr_ok;
    assign reg_idx_o = adr_i[4:2];
    assign wr_data_o = dat_i;
    assign wr_sel_o  = sel_i;

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign dat_o = dat_q;

    // Handshake FSM with registered termination and read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SLV_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            case (state_q)
                SLV_IDLE: begin
                    if (sample) begin
                        state_q <= SLV_RESP;
                        ack_q   <= addr_ok;
                        err_q   <= ~addr_ok;
                        dat_q   <= (addr_ok && !we_i) ? rd_data_i : 32'h0;
                    end else begin
                        state_q <= SLV_IDLE;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        dat_q   <= 32'h0;
                    end
                end
                SLV_RESP: begin
                    state_q <= SLV_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    dat_q   <= 32'h0;
                end
                default: begin
                    state_q <= SLV_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    dat_q   <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone-mapped 32-bit timer with prescaler, compare match, optional
// auto-reload and a level interrupt gated by CTRL.IE.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int unsigned PRESC_W     = 16,
    parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [7:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_inta_o
);

    logic               reg_wr;
    logic [2:0]         reg_idx;
    logic [31:0]        wr_data;
    logic [3:0]         wr_sel;
    logic [31:0]        rd_data;

    logic [2:0]         ctrl_q,    ctrl_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [PRESC_W-1:0] pcnt_q,    pcnt_d;
    logic [31:0]        count_q,   count_d;
    logic [31:0]        compare_q, compare_d;
    logic               pend_q,    pend_d;

    logic               wr_any;
    logic               tick;
    logic               match;

    wb_slave_if u_slv (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .cyc_i     (wb_cyc_i),
        .stb_i     (wb_stb_i),
        .we_i      (wb_we_i),
        .adr_i     (wb_adr_i),
        .dat_i     (wb_dat_i),
        .sel_i     (wb_sel_i),
        .rd_data_i (rd_data),
        .dat_o     (wb_dat_o),
        .ack_o     (wb_ack_o),
        .err_o     (wb_err_o),
        .reg_wr_o  (reg_wr),
        .reg_idx_o (reg_idx),
        .wr_data_o (wr_data),
        .wr_sel_o  (wr_sel)
    );

    // An all-zero byte enable is acknowledged but must leave every register untouched.
    assign wr_any    = reg_wr & (|wr_sel);
    assign tick      = ctrl_q[CTRL_EN] & (pcnt_q == presc_q);
    assign match     = tick & (count_q == compare_q);
    assign wb_inta_o = pend_q & ctrl_q[CTRL_IE];

    // Read multiplexer; the slave captures it at the sampling edge.
    always_comb begin
        rd_data = 32'h0;
        case (reg_idx)
            REG_CTRL:    rd_data = {29'd0, ctrl_q};
            REG_PRESC:   rd_data = 32'(presc_q);
            REG_COUNT:   rd_data = count_q;
            REG_COMPARE: rd_data = compare_q;
            REG_STATUS:  rd_data = {31'd0, pend_q};
            default:     rd_data = 32'h0;
        endcase
    end

    // Next-state for configuration, prescaler, counter and pending flag.
    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        compare_d = compare_q;
        pend_d    = pend_q;

        if (wr_any && (reg_idx == REG_CTRL)) begin
            ctrl_d = 3'(merge_lanes({29'd0, ctrl_q}, wr_data, wr_sel));
        end else begin
            ctrl_d = ctrl_q;
        end

        if (wr_any && (reg_idx == REG_PRESC)) begin
            presc_d = PRESC_W'(merge_lanes(32'(presc_q), wr_data, wr_sel));
            pcnt_d  = '0;
        end else if (tick) begin
            presc_d = presc_q;
            pcnt_d  = '0;
        end else if (ctrl_q[CTRL_EN]) begin
            presc_d = presc_q;
            pcnt_d  = pcnt_q + PRESC_W'(1'b1);
        end else begin
            presc_d = presc_q;
            pcnt_d  = pcnt_q;
        end

        // A bus write wins over the tick; the match itself was judged on the old count.
        if (wr_any && (reg_idx == REG_COUNT)) begin
            count_d = merge_lanes(count_q, wr_data, wr_sel);
        end else if (match && ctrl_q[CTRL_AR]) begin
            count_d = 32'h0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        if (wr_any && (reg_idx == REG_COMPARE)) begin
            compare_d = merge_lanes(compare_q, wr_data, wr_sel);
        end else begin
            compare_d = compare_q;
        end

        if (match) begin
            pend_d = 1'b1;
        end else if (wr_any && (reg_idx == REG_STATUS) && wr_sel[0] && wr_data[STATUS_PEND]) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q    <= 3'd0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            count_q   <= 32'h0;
            compare_q <= RST_COMPARE;
            pend_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios plus randomized bus
// traffic compared cycle by cycle against a behavioural timer model.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack, err, inta;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the programmer-visible timer.
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    int unsigned m_phase;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_pend;
    logic        m_busy;
    logic        e_ack, e_err;
    logic [31:0] e_dat;

    logic        r_ack, r_err, r_inta;
    logic [31:0] rd;

    always #5 clk = ~clk;

    wb_timer dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_sel_i  (sel),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .wb_inta_o (inta)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = 3'd0; m_presc = 16'd0; m_phase = 0; m_count = 32'h0;
        m_compare = 32'hFFFF_FFFF; m_pend = 1'b0; m_busy = 1'b0;
        e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
    endtask

    // Predicts whether the next clock edge produces a compare match.
    function automatic logic match_next();
        return m_ctrl[0] && (((m_phase + 1) % (32'(m_presc) + 1)) == 0) && (m_count == m_compare);
    endfunction

    // One clock edge of the model, using the bus values currently driven.
    task automatic model_edge();
        logic accept, valid, tick, hit;
        logic [31:0] rv, old_count, tmp;
        accept = cyc && stb && !m_busy;
        valid  = adr < 8'h14;
        case (adr[4:2])
            3'd0: rv = {29'd0, m_ctrl};
            3'd1: rv = {16'd0, m_presc};
            3'd2: rv = m_count;
            3'd3: rv = m_compare;
            3'd4: rv = {31'd0, m_pend};
            default: rv = 32'h0;
        endcase
        old_count = m_count;
        tick = 1'b0;
        hit  = 1'b0;
        if (m_ctrl[0]) begin
            m_phase = (m_phase + 1) % (32'(m_presc) + 1);
            tick = (m_phase == 0);
        end
        if (tick) begin
            hit = (m_count == m_compare);
            m_count = (hit && m_ctrl[2]) ? 32'h0 : m_count + 32'd1;
            if (hit) m_pend = 1'b1;
        end
        if (accept && we && valid && (sel != 4'h0)) begin
            case (adr[4:2])
                3'd0: begin tmp = lanes({29'd0, m_ctrl}, dat_w, sel); m_ctrl = tmp[2:0]; end
                3'd1: begin tmp = lanes({16'd0, m_presc}, dat_w, sel); m_presc = tmp[15:0]; m_phase = 0; end
                3'd2: m_count = lanes(old_count, dat_w, sel);
                3'd3: m_compare = lanes(m_compare, dat_w, sel);
                3'd4: if (sel[0] && dat_w[0] && !hit) m_pend = 1'b0;
                default: ;
            endcase
        end
        m_busy = accept;
        e_ack  = accept && valid;
        e_err  = accept && !valid;
        e_dat  = (accept && valid && !we) ? rv : 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("dat", dat_r, e_dat);
        chk("inta", {31'd0, inta}, {31'd0, m_pend & m_ctrl[1]});
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, output logic [31:0] rdata);
        rdata = 32'h0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        for (int i = 0; i < hold; i++) begin
            cycle();
            if (i == 0) begin
                rdata = dat_r; r_ack = ack; r_err = err; r_inta = inta;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h0; dat_w = 32'h0; sel = 4'h0;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_inta", {31'd0, inta}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int budget;
        logic [7:0]  ra;
        logic [31:0] rdat;
        logic [3:0]  rs;
        logic        rw;
        int          rh;

        r_ack = 1'b0; r_err = 1'b0; r_inta = 1'b0;
        do_reset();

        // Reset values of every register.
        bus(1'b0, 8'h00, 32'h0, 4'hF, 1, rd); chk("rst_ctrl", rd, 32'h0);
        bus(1'b0, 8'h04, 32'h0, 4'hF, 1, rd); chk("rst_presc", rd, 32'h0);
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1, rd); chk("rst_count", rd, 32'h0);
        bus(1'b0, 8'h0C, 32'h0, 4'hF, 1, rd); chk("rst_compare", rd, 32'hFFFF_FFFF);
        bus(1'b0, 8'h10, 32'h0, 4'hF, 1, rd); chk("rst_status", rd, 32'h0);

        // Single byte-lane write.
        bus(1'b1, 8'h08, 32'hAABB_CCDD, 4'b0010, 1, rd);
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1, rd); chk("lane_write", rd, 32'h0000_CC00);
        bus(1'b1, 8'h0C, 32'h1234_5678, 4'b0000, 1, rd);
        chk("sel0_ack", {31'd0, r_ack}, 32'd1);
        bus(1'b0, 8'h0C, 32'h0, 4'hF, 1, rd); chk("sel0_nochange", rd, 32'hFFFF_FFFF);

        // Unmapped offsets terminate with error and change nothing.
        bus(1'b0, 8'h14, 32'h0, 4'hF, 1, rd);
        chk("err14_err", {31'd0, r_err}, 32'd1);
        chk("err14_ack", {31'd0, r_ack}, 32'd0);
        chk("err14_dat", rd, 32'h0);
        bus(1'b1, 8'hF8, 32'h0000_0007, 4'hF, 1, rd);
        chk("errF8_err", {31'd0, r_err}, 32'd1);
        bus(1'b0, 8'h00, 32'h0, 4'hF, 1, rd); chk("err_ctrl_kept", rd, 32'h0);
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1, rd); chk("err_count_kept", rd, 32'h0000_CC00);

        // Auto-reload match after six ticks.
        do_reset();
        bus(1'b1, 8'h0C, 32'h5, 4'hF, 1, rd);
        bus(1'b1, 8'h04, 32'h0, 4'hF, 1, rd);
        bus(1'b1, 8'h00, 32'h7, 4'hF, 1, rd);
        repeat (5) cycle();
        chk("ar_inta", {31'd0, inta}, 32'd1);
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1, rd); chk("ar_count", rd, 32'h0);
        bus(1'b0, 8'h10, 32'h0, 4'hF, 1, rd); chk("ar_status", rd, 32'h1);

        // Counter wrap without a flag.
        do_reset();
        bus(1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, 1, rd);
        bus(1'b1, 8'h0C, 32'h10, 4'hF, 1, rd);
        bus(1'b1, 8'h04, 32'h3, 4'hF, 1, rd);
        bus(1'b1, 8'h00, 32'h1, 4'hF, 1, rd);
        repeat (3) cycle();
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1, rd); chk("wrap_count", rd, 32'h0);
        bus(1'b0, 8'h10, 32'h0, 4'hF, 1, rd); chk("wrap_pend", rd, 32'h0);

        // Set beats clear when W1C lands on a match edge.
        do_reset();
        bus(1'b1, 8'h0C, 32'h2, 4'hF, 1, rd);
        bus(1'b1, 8'h00, 32'h7, 4'hF, 1, rd);
        budget = 0;
        while (!m_pend && budget < 20) begin cycle(); budget++; end
        chk("pend_wait_budget", {31'd0, (budget >= 20)}, 32'd0);
        budget = 0;
        while (!match_next() && budget < 20) begin cycle(); budget++; end
        chk("match_wait_budget", {31'd0, (budget >= 20)}, 32'd0);
        bus(1'b1, 8'h10, 32'h1, 4'hF, 1, rd);
        chk("w1c_set_wins", {31'd0, r_inta}, 32'd1);
        budget = 0;
        while (match_next() && budget < 20) begin cycle(); budget++; end
        chk("nomatch_wait_budget", {31'd0, (budget >= 20)}, 32'd0);
        bus(1'b1, 8'h10, 32'h1, 4'hF, 1, rd);
        chk("w1c_clear_inta", {31'd0, r_inta}, 32'd0);
        bus(1'b1, 8'h00, 32'h0, 4'hF, 1, rd);

        // Reset during the response phase.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h0C; dat_w = 32'h22; sel = 4'hF;
        cycle();
        rst = 1'b1;
        #1;
        chk("midresp_ack", {31'd0, ack}, 32'd0);
        model_reset();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus(1'b0, 8'h0C, 32'h0, 4'hF, 1, rd); chk("midresp_compare", rd, 32'hFFFF_FFFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 8) ra = 8'($urandom_range(8'h14, 8'hFF));
            else ra = {3'd0, 3'($urandom_range(0, 4)), 2'($urandom_range(0, 3))};
            rw = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            case (ra[4:2])
                3'd0: rdat = 32'($urandom_range(0, 7));
                3'd1: rdat = 32'($urandom_range(0, 3));
                3'd2: rdat = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                        : 32'($urandom_range(0, 12));
                3'd3: rdat = 32'($urandom_range(0, 12));
                default: rdat = 32'($urandom_range(0, 1));
            endcase
            rh = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 4) : 1;
            bus(rw, ra, rdat, rs, rh, rd);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter PRESC_W, default 16, width of the PRESCALE register and the internal prescale counter.
REQ-002 Parameter RST_COMPARE, default 32'hFFFF_FFFF, reset value of COMPARE.
REQ-003 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 wb_cyc_i  in  1  bus cycle valid.
REQ-006 wb_stb_i  in  1  strobe; request = wb_cyc_i & wb_stb_i.
REQ-007 wb_we_i  in  1  1 = write, 0 = read.
REQ-008 wb_adr_i  in  8  byte address; bits [4:2] select register, bits [1:0] ignored.
REQ-009 wb_dat_i  in  32  write data.
REQ-010 wb_sel_i  in  4  byte enables for writes; ignored on reads.
REQ-011 wb_dat_o  out  32  registered read data, valid while wb_ack_o = 1, else 0.
REQ-012 wb_ack_o  out  1  normal termination, one-cycle pulse.
REQ-013 wb_err_o  out  1  error termination, one-cycle pulse.
REQ-014 wb_inta_o  out  1  level interrupt = STATUS.PEND & CTRL.IE.

Function
REQ-015 Register map: 0x00 CTRL (bit0 EN, bit1 IE, bit2 AR auto-reload); 0x04 PRESCALE [PRESC_W-1:0]; 0x08 COUNT [31:0] RW; 0x0C COMPARE [31:0] RW; 0x10 STATUS (bit0 PEND, write-1-to-clear); unimplemented bits read 0.
REQ-016 Request sampled at edge N when request = 1 and wb_ack_o = wb_err_o = 0; ack or err asserted after edge N for exactly one cycle, deasserted after edge N+1.
REQ-017 Back-to-back requests held high get one response every second cycle (no response in the cycle following a response).
REQ-018 Offsets 0x14-0xFF: wb_err_o instead of wb_ack_o; no state change; wb_dat_o = 0.
REQ-019 Writes commit at sampling edge N, byte lanes per wb_sel_i; wb_sel_i = 0 acks with no change.
REQ-020 Read data captured at edge N; reads have no side effects.
REQ-021 Handshake FSM states: IDLE, RESP; IDLE->RESP on sampled request; RESP->IDLE unconditionally.
REQ-022 With EN = 1 the prescale counter increments each cycle; when equal to PRESCALE it clears and issues a tick; PRESCALE = 0 gives a tick every cycle.
REQ-023 With EN = 0 the prescale counter holds; clearing EN does not reset it.
REQ-024 On tick: if COUNT == COMPARE, set PEND and COUNT <= 0 when AR = 1, else COUNT <= COUNT + 1; otherwise COUNT <= COUNT + 1.
REQ-025 COUNT wraps 32'hFFFF_FFFF -> 0 with no flag.
REQ-026 Bus write to COUNT in the same cycle as a tick: bus value wins, tick's increment discarded; compare uses the pre-write COUNT.
REQ-027 Writing PRESCALE clears the prescale counter.
REQ-028 STATUS write with bit0 = 1 coincident with a new match: PEND stays 1 (set wins).
REQ-029 wb_inta_o is combinational from registered PEND and IE; no extra latency.

Reset
REQ-030 On wb_rst_i = 1, immediately: CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = RST_COMPARE, PEND = 0, prescale counter = 0, FSM = IDLE.
REQ-031 Outputs during and after reset until first response: wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, wb_inta_o = 0.
REQ-032 Reset during RESP aborts the response; the pending write (already committed) is overwritten by reset values.

Structure
REQ-033 Register offsets, CTRL/STATUS bit positions and the FSM state enum live in shared package wb_timer_pkg.
REQ-034 Single module; one natural sub-module, wb_slave_if (handshake FSM, address decode, ack/err generation), reusable by later Wishbone peripherals.

Verification
REQ-035 Write 0x0C = 0x5, 0x04 = 0, 0x00 = 0x7 -> 6 ticks later PEND = 1, COUNT = 0, wb_inta_o = 1; read 0x10 returns 0x1.
REQ-036 Read 0x14 -> wb_err_o pulse one cycle after sampling, wb_ack_o = 0, wb_dat_o = 0, registers unchanged.
REQ-037 Write 0x08 = 0xAABBCCDD with sel = 4'b0010 after reset -> read 0x08 returns 0x0000CC00 (EN = 0).
REQ-038 COUNT = 0xFFFFFFFF, COMPARE = 0x10, PRESCALE = 3, EN = 1 -> after 4 cycles COUNT = 0, PEND = 0.
REQ-039 PEND = 1, write 0x10 = 1 in the tick cycle of a new match -> PEND remains 1; next W1C without match clears it, wb_inta_o falls same cycle.
REQ-040 Assert wb_rst_i mid-RESP after write 0x0C = 0x22 -> wb_ack_o drops at once, COMPARE reads RST_COMPARE.
